shift_piso_tx: RTL and testbench
================================

# shift_piso_tx

Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with a frame-valid and last-bit marker. It is the transmit end of the serial shift link whose receive end is the 4-bit SIPO shift register. Its serial stream feeds that register, or any serial consumer, directly. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 4, word width in bits. Legal range is 2 to 32.
- MSB_FIRST, 1, bit order. 1 sends p_in[WIDTH-1] first; 0 sends p_in[0] first.
- clk, input, 1, single clock. All state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- p_in, input, WIDTH, parallel word. Sampled only on an accepted transfer.
- p_valid, input, 1, producer has a word on p_in.
- p_ready, output, 1, block can accept a word this cycle.
- s_out, output, 1, serial data bit.
- s_valid, output, 1, s_out carries a frame bit this cycle.
- s_last, output, 1, current bit is the final bit of the word.
- busy, output, 1, a frame is in progress (equal to s_valid).

## Operation
- FSM has two states: IDLE and SHIFT.
- IDLE:
  - p_ready=1, s_valid=0, s_out=0, s_last=0.
  - When p_valid=1, the word is accepted at the edge. The shift register loads p_in, the bit counter clears to 0, and the FSM moves to SHIFT.
- SHIFT:
  - s_valid=1 and busy=1.
  - s_out is the current end bit of the shift register: bit WIDTH-1 when MSB_FIRST=1, bit 0 when MSB_FIRST=0.
  - On each edge the register shifts one position and the counter increments.
- Last bit (counter == WIDTH-1):
  - s_last=1 and p_ready=1.
  - If p_valid=1, the new word loads, the counter clears, and the FSM stays in SHIFT. The next bit is bit 0 of the new word, with no gap.
  - If p_valid=0, the FSM returns to IDLE.
- p_ready=0 during SHIFT except on the last bit. A p_valid during those cycles is not accepted. The producer holds p_in and p_valid until p_ready.
- p_ready is combinational from state and counter only, never from p_valid.
- Counter width is $clog2(WIDTH), unsigned. It never exceeds WIDTH-1. Vacated shift-register bits fill with 0.
- Reset (any time, including mid-frame):
  - FSM goes to IDLE and the counter and shift register to 0.
  - s_out=0, s_valid=0, s_last=0, busy=0, p_ready=1.
  - A partially sent word is dropped and no bits are emitted for it.
  - No transfer is accepted while rst_n=0.

## Timing
- Latency: transfer accepted at edge N; first bit valid in the cycle after edge N. Bit k is valid in the cycle after edge N+k, and s_last is high in the cycle after edge N+WIDTH-1.
- Throughput: one word per WIDTH cycles in continuous streaming.
- All outputs except p_ready are registered or decoded from registered state. There is no combinational path from p_in or p_valid to any output.
- Reset assertion takes effect immediately. Release is synchronized externally. The first possible transfer is at the first edge with rst_n=1.

## Structure
- Shared package shift_pkg holds:
  - the state enum (IDLE, SHIFT);
  - localparam CNT_W = $clog2(WIDTH) helper;
  - the shared bit-order constants, which the SIPO receiver also uses.
- Sub-module shift_bit_cnt is a modulo-WIDTH counter with clear, enable, and terminal-count output. It drives s_last and the p_ready decode.
- Top level holds the FSM, the shift register, and the output decode.

## Test plan
- Reset and idle: hold rst_n=0 for 3 cycles, then release with p_valid=0 for 10 cycles. Required: s_out=0, s_valid=0, s_last=0, p_ready=1 throughout.
- Single word, WIDTH=4, MSB_FIRST=1: p_in=4'b1011 accepted. Required: s_out=1,0,1,1 over 4 cycles with s_valid=1, s_last only on the 4th bit, then IDLE.
- Back-to-back: send 4'b1011 then 4'b0110 with p_valid held high. Required:
  - 8 contiguous valid bits 1,0,1,1,0,1,1,0;
  - s_last on bits 4 and 8;
  - p_ready high only in the initial IDLE cycle and on bits 4 and 8.
- Stall: p_valid rises on bit 2 of a frame with p_in=4'b0011. Required: not accepted until bit 4, and the second frame reads 0,0,1,1.
- LSB-first, WIDTH=8, MSB_FIRST=0: p_in=8'hA5. Required: s_out=1,0,1,0,0,1,0,1.
- Reset mid-frame: assert rst_n=0 during bit 2 of 4'b1111. Required: s_valid=0 and s_out=0 immediately, no further bits, p_ready=1. The next word after release is transmitted intact.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift link (PISO transmitter and SIPO receiver).
// Holds the transmitter state encoding, bit-order constants and counter sizing helper.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit-order selectors shared by both ends of the link
    localparam bit MSB_FIRST_ORDER = 1'b1;
    localparam bit LSB_FIRST_ORDER = 1'b0;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Bit-counter width for a WIDTH-bit word; never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_bit_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear, count enable and terminal count.
// Clear has priority over enable so a reload on the last bit restarts at zero.
module shift_bit_cnt
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/shift_piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts it
// out one bit per clock, reloading on the last bit so consecutive words have no gap.
module shift_piso_tx
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = MSB_FIRST_ORDER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic             in_shift;
    logic             cnt_tc;
    logic             last_bit;
    logic             accept;

    assign in_shift = (state_q == SHIFT);
    assign last_bit = in_shift & cnt_tc;

    // Ready depends only on state and counter so there is no valid->ready loop
    assign p_ready = ~in_shift | cnt_tc;
    assign accept  = p_valid & p_ready;

    // Vacated positions fill with zero in either bit order
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            IDLE: begin
                if (p_valid) begin
                    sreg_d  = p_in;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = sreg_shifted;
                if (cnt_tc) begin
                    if (p_valid) begin
                        sreg_d = p_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    shift_bit_cnt #(
        .WIDTH(WIDTH)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (in_shift),
        .tc_o  (cnt_tc)
    );

    assign s_valid = in_shift;
    assign busy    = in_shift;
    assign s_last  = last_bit;
    assign s_out   = in_shift & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);

endmodule

// File: tb/tb_shift_piso_tx.sv
// Bench for shift_piso_tx: directed vector tables for the 4-bit MSB-first instance,
// hand sequences for reset and the 8-bit LSB-first instance, then randomized traffic.
module tb_shift_piso_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pin4;
    logic       pv4;
    logic       pr4, so4, sv4, sl4, busy4;
    logic [7:0] pin8;
    logic       pv8;
    logic       pr8, so8, sv8, sl8, busy8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .p_in(pin4), .p_valid(pv4), .p_ready(pr4),
        .s_out(so4), .s_valid(sv4), .s_last(sl4), .busy(busy4)
    );

    shift_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .p_in(pin8), .p_valid(pv8), .p_ready(pr8),
        .s_out(so8), .s_valid(sv8), .s_last(sl8), .busy(busy8)
    );

    typedef struct {
        logic       pv;
        logic [3:0] pin;
        logic       so;
        logic       sv;
        logic       sl;
        logic       pr;
    } vec_t;

    typedef struct {
        logic b;
        logic l;
    } sbit_t;

    vec_t  vecs[$];
    sbit_t q4[$];
    sbit_t q8[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check4(input string nm, input logic so, input logic sv,
                          input logic sl, input logic pr);
        chk({nm, ".s_out4"}, so4, so);
        chk({nm, ".s_valid4"}, sv4, sv);
        chk({nm, ".s_last4"}, sl4, sl);
        chk({nm, ".p_ready4"}, pr4, pr);
        chk({nm, ".busy4"}, busy4, sv);
    endtask

    task automatic check8(input string nm, input logic so, input logic sv,
                          input logic sl, input logic pr);
        chk({nm, ".s_out8"}, so8, so);
        chk({nm, ".s_valid8"}, sv8, sv);
        chk({nm, ".s_last8"}, sl8, sl);
        chk({nm, ".p_ready8"}, pr8, pr);
        chk({nm, ".busy8"}, busy8, sv);
    endtask

    task automatic add(input logic pv, input logic [3:0] pin, input logic so,
                       input logic sv, input logic sl, input logic pr);
        vec_t v;
        v.pv = pv; v.pin = pin; v.so = so; v.sv = sv; v.sl = sl; v.pr = pr;
        vecs.push_back(v);
    endtask

    // Each record: inputs presented this cycle, outputs expected in the same cycle
    task automatic run_vecs(input string nm);
        foreach (vecs[i]) begin
            @(negedge clk);
            pv4  = vecs[i].pv;
            pin4 = vecs[i].pin;
            #1;
            check4($sformatf("%s[%0d]", nm, i), vecs[i].so, vecs[i].sv, vecs[i].sl, vecs[i].pr);
        end
        vecs.delete();
    endtask

    initial begin
        logic [7:0] w8;
        logic       e_so, e_sv, e_sl, e_pr, acc, pend4, pend8;

        rst_n = 1'b0; pv4 = 1'b0; pin4 = '0; pv8 = 1'b0; pin8 = '0;

        // Reset held for three cycles, then idle with p_valid low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check4($sformatf("rst[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b1);
            check8($sformatf("rst[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check4($sformatf("idle[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b1);
            check8($sformatf("idle[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Back-to-back 1011 then 0110 with p_valid held high
        add(1, 4'b1011, 0, 0, 0, 1);
        add(1, 4'b0110, 1, 1, 0, 0);
        add(1, 4'b0110, 0, 1, 0, 0);
        add(1, 4'b0110, 1, 1, 0, 0);
        add(1, 4'b0110, 1, 1, 1, 1);
        add(0, 4'b0000, 0, 1, 0, 0);
        add(0, 4'b0000, 1, 1, 0, 0);
        add(0, 4'b0000, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 1);
        run_vecs("b2b");

        // Stall: 0011 offered from bit 2, accepted only on bit 4
        add(1, 4'b1001, 0, 0, 0, 1);
        add(0, 4'b0000, 1, 1, 0, 0);
        add(1, 4'b0011, 0, 1, 0, 0);
        add(1, 4'b0011, 0, 1, 0, 0);
        add(1, 4'b0011, 1, 1, 1, 1);
        add(0, 4'b0000, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 0, 0);
        add(0, 4'b0000, 1, 1, 0, 0);
        add(0, 4'b0000, 1, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 1);
        run_vecs("stall");

        // Reset during bit 2 of 1111, with a word offered that must not be taken
        @(negedge clk); pv4 = 1'b1; pin4 = 4'b1111; #1;
        check4("mid.idle", 0, 0, 0, 1);
        @(negedge clk); pv4 = 1'b0; #1;
        check4("mid.bit1", 1, 1, 0, 0);
        @(negedge clk); #1;
        check4("mid.bit2", 1, 1, 0, 0);
        #1; rst_n = 1'b0; pv4 = 1'b1; pin4 = 4'b0101; #1;
        check4("mid.rst_now", 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check4($sformatf("mid.rst[%0d]", i), 0, 0, 0, 1);
        end
        @(negedge clk); rst_n = 1'b1; pv4 = 1'b0;
        add(1, 4'b0101, 0, 0, 0, 1);
        add(0, 4'b0000, 0, 1, 0, 0);
        add(0, 4'b0000, 1, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 0, 0);
        add(0, 4'b0000, 1, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 1);
        run_vecs("after_rst");

        // LSB-first 8-bit word A5
        w8 = 8'hA5;
        @(negedge clk); pv8 = 1'b1; pin8 = w8; #1;
        check8("lsb.idle", 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); pv8 = 1'b0; pin8 = '0; #1;
            check8($sformatf("lsb.bit%0d", k), w8[k], 1'b1, k == 7, k == 7);
        end
        @(negedge clk); #1;
        check8("lsb.done", 0, 0, 0, 1);

        // Randomized traffic on both instances against a queue-of-bits model
        pend4 = 1'b0; pend8 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            e_sv = (q4.size() > 0);
            e_so = e_sv ? q4[0].b : 1'b0;
            e_sl = e_sv ? q4[0].l : 1'b0;
            e_pr = (q4.size() <= 1);
            check4($sformatf("rnd4[%0d]", c), e_so, e_sv, e_sl, e_pr);
            e_sv = (q8.size() > 0);
            e_so = e_sv ? q8[0].b : 1'b0;
            e_sl = e_sv ? q8[0].l : 1'b0;
            e_pr = (q8.size() <= 1);
            check8($sformatf("rnd8[%0d]", c), e_so, e_sv, e_sl, e_pr);

            if (!pend4) begin
                pv4  = ($urandom_range(0, 3) != 0);
                pin4 = 4'($urandom);
            end
            acc = pv4 && (q4.size() <= 1);
            if (q4.size() > 0) void'(q4.pop_front());
            if (acc) begin
                for (int k = 0; k < 4; k++) begin
                    sbit_t s;
                    s.b = pin4[3 - k];
                    s.l = (k == 3);
                    q4.push_back(s);
                end
            end
            pend4 = pv4 && !acc;

            if (!pend8) begin
                pv8  = ($urandom_range(0, 3) != 0);
                pin8 = 8'($urandom);
            end
            acc = pv8 && (q8.size() <= 1);
            if (q8.size() > 0) void'(q8.pop_front());
            if (acc) begin
                for (int k = 0; k < 8; k++) begin
                    sbit_t s;
                    s.b = pin8[k];
                    s.l = (k == 7);
                    q8.push_back(s);
                end
            end
            pend8 = pv8 && !acc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
